// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   FB_RESET_PC : default first fetch address after reset
//   FB_NOP      : instruction presented to ID when the queue is empty
//   fb_entry_t  : one queue entry, {pc, instr}
package fetch_buffer_pkg;

  localparam logic [31:0] FB_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FB_NOP      = 32'h0000_0000;
  localparam logic [31:0] FB_PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  function automatic logic [31:0] fb_pc_next(input logic [31:0] pc);
    return pc + FB_PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} entries.
// Ports:
//   clk, reset      : clock, async active-low reset
//   push, din       : write an entry (ignored on flush)
//   pop             : drop the head entry (ignored on flush or when empty)
//   flush           : empty the queue; wins over push and pop
//   dout            : head entry (contents undefined when empty)
//   full, empty     : status
//   count           : occupancy, 0..DEPTH
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fb_entry_t        din,
  input  logic             pop,
  input  logic             flush,
  output fb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: empty masks the head at the top level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between a variable-latency, in-order
// instruction memory and the IF/ID register. Requests are issued against a
// credit pool of DEPTH slots shared by queued entries, live in-flight
// requests and in-flight requests whose responses must be thrown away after
// a redirect.
// Ports:
//   clk, reset                : clock, async active-low reset
//   req_valid/req_addr/req_ready : fetch request handshake
//   resp_valid/resp_data      : in-order memory response
//   stall                     : ID holds the head entry
//   redirect/redirect_pc      : flush and restart fetch at redirect_pc
//   out_valid/instr_out/pc4_out : head entry (zeros when empty)
//   err                       : sticky, response seen with nothing in flight
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FB_RESET_PC,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        err
);

  localparam logic [CNT_W+1:0] DEPTH_W = (CNT_W + 2)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W+1:0] credit_used;

  logic      fifo_full;
  logic      fifo_empty;
  fb_entry_t head;

  logic accept;
  logic resp_drop;    // stale response, owed to an earlier redirect
  logic resp_take;    // live response for the current fetch stream
  logic resp_orphan;  // response with nothing outstanding
  logic push;
  logic pop;

  assign credit_used = {2'b00, occupancy} + {2'b00, inflight} + {2'b00, discard};

  // Held low while reset is asserted so the request port is quiet even
  // though the cleared counters would otherwise grant credit.
  assign req_valid = reset && !redirect && (credit_used < DEPTH_W);
  assign req_addr  = fetch_pc;
  assign accept    = req_valid && req_ready;

  assign resp_drop   = resp_valid && (discard != '0);
  assign resp_take   = resp_valid && (discard == '0) && (inflight != '0);
  assign resp_orphan = resp_valid && (discard == '0) && (inflight == '0);

  // A redirect flushes the queue, so the coincident response and any pop
  // that cycle are cancelled.
  assign push = resp_take && !redirect && !fifo_full;
  assign pop  = !fifo_empty && !stall && !redirect;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ('{pc: resp_pc, instr: resp_data}),
    .pop   (pop),
    .flush (redirect),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign out_valid = !fifo_empty;
  assign instr_out = fifo_empty ? FB_NOP : head.instr;
  assign pc4_out   = fifo_empty ? 32'b0  : fb_pc_next(head.pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      err      <= 1'b0;
    end else begin
      if (resp_orphan) err <= 1'b1;

      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        inflight <= '0;
        // Everything still outstanding becomes stale. accept is 0 here, and
        // a response arriving now retires one outstanding slot.
        discard  <= discard + inflight - CNT_W'(resp_drop || resp_take);
      end else begin
        if (accept)    fetch_pc <= fb_pc_next(fetch_pc);
        if (resp_take) resp_pc  <= fb_pc_next(resp_pc);
        inflight <= inflight + CNT_W'(accept) - CNT_W'(resp_take);
        discard  <= discard - CNT_W'(resp_drop);
      end
    end
  end

endmodule
